// File: rtl/fas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fas_pkg : shared FFT/spectral-analysis types and constants           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fas_pkg;

  localparam int FFT_NPT = 16;
  localparam int FFT_DW  = 16;
  localparam int MAG_W   = 33;

  // One FFT bin, signed 8.8 real/imag; real occupies the upper half.
  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    FA_IDLE = 1'b0,
    FA_SCAN = 1'b1
  } fa_state_t;

endpackage
`default_nettype wire

// File: rtl/mag_sq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mag_sq : one-stage registered re^2 + im^2 with valid/index sideband  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mag_sq
  import fas_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [3:0]       i_idx,
  input  cplx_t            i_bin,
  output logic             o_valid,
  output logic [3:0]       o_idx,
  output logic [MAG_W-1:0] o_mag
);

  logic signed [2*FFT_DW-1:0] w_re_sq;
  logic signed [2*FFT_DW-1:0] w_im_sq;
  logic [MAG_W-1:0]           w_mag;
  logic                       r_valid;
  logic [3:0]                 r_idx;
  logic [MAG_W-1:0]           r_mag;

  // Squares are never negative, so zero-extension into the sum is exact.
  assign w_re_sq = i_bin.re * i_bin.re;
  assign w_im_sq = i_bin.im * i_bin.im;
  assign w_mag   = {1'b0, w_re_sq} + {1'b0, w_im_sq};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= 4'd0;
      r_mag   <= '0;
    end else begin
      r_valid <= i_valid;
      r_idx   <= i_idx;
      r_mag   <= w_mag;
    end
  end

  assign o_valid = r_valid;
  assign o_idx   = r_idx;
  assign o_mag   = r_mag;

endmodule
`default_nettype wire

// File: rtl/freq_analyzer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_analyzer : peak-bin finder for 16-point FFT frames, with a      |
// | pending frame buffer. Option macro: FREQ_SKIP_DC_EN (ignore bin 0).  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module freq_analyzer
  import fas_pkg::*;
#(
  parameter int NPT = 16,
  parameter int DW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic [3:0]    freq,
  output logic          done,
  output logic          overrun
);

`ifdef FREQ_SKIP_DC_EN
  localparam logic [3:0] c_FIRST_BIN = 4'd1;
`else
  localparam logic [3:0] c_FIRST_BIN = 4'd0;
`endif
  localparam logic [3:0] c_LAST_BIN = 4'(NPT - 1);

  logic [2*DW-1:0]  w_in    [NPT];
  logic [2*DW-1:0]  r_w_buf [NPT];
  logic [2*DW-1:0]  r_p_buf [NPT];
  logic             r_p_full;
  fa_state_t        r_state;
  logic [3:0]       r_idx;

  logic             w_last;
  logic             w_w_from_in;
  logic             w_w_from_p;
  logic             w_p_load;

  logic             r_rd_valid;
  logic [3:0]       r_rd_idx;
  cplx_t            r_rd_bin;
  logic             w_mag_in_valid;

  logic             w_m_valid;
  logic [3:0]       w_m_idx;
  logic [MAG_W-1:0] w_m_mag;
  logic             w_take;
  logic [3:0]       w_new_idx;
  logic [MAG_W-1:0] r_best_mag;
  logic [3:0]       r_best_idx;
  logic [3:0]       r_freq;
  logic             r_done;
  logic             r_overrun;

  assign w_in[0]  = fft_d0;   assign w_in[1]  = fft_d1;
  assign w_in[2]  = fft_d2;   assign w_in[3]  = fft_d3;
  assign w_in[4]  = fft_d4;   assign w_in[5]  = fft_d5;
  assign w_in[6]  = fft_d6;   assign w_in[7]  = fft_d7;
  assign w_in[8]  = fft_d8;   assign w_in[9]  = fft_d9;
  assign w_in[10] = fft_d10;  assign w_in[11] = fft_d11;
  assign w_in[12] = fft_d12;  assign w_in[13] = fft_d13;
  assign w_in[14] = fft_d14;  assign w_in[15] = fft_d15;

  // At the end of a scan a waiting frame in P goes first; a frame arriving
  // that same cycle then takes its place in P so arrival order is kept.
  assign w_last      = (r_state == FA_SCAN) && (r_idx == c_LAST_BIN);
  assign w_w_from_p  = w_last && r_p_full;
  assign w_w_from_in = fft_valid && !r_p_full && ((r_state == FA_IDLE) || w_last);
  assign w_p_load    = fft_valid && !w_w_from_in;

  always_ff @(posedge clk) begin
    if (w_w_from_in) begin
      r_w_buf <= w_in;
    end else if (w_w_from_p) begin
      r_w_buf <= r_p_buf;
    end
    if (w_p_load) begin
      r_p_buf <= w_in;
    end
    r_rd_bin <= r_w_buf[r_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FA_IDLE;
      r_idx      <= 4'd0;
      r_p_full   <= 1'b0;
      r_overrun  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_idx   <= 4'd0;
    end else begin
      if (w_w_from_in || w_w_from_p) begin
        r_state <= FA_SCAN;
        r_idx   <= 4'd0;
      end else if (w_last) begin
        r_state <= FA_IDLE;
        r_idx   <= 4'd0;
      end else if (r_state == FA_SCAN) begin
        r_idx <= r_idx + 4'd1;
      end

      if (w_p_load) begin
        r_p_full <= 1'b1;
      end else if (w_w_from_p) begin
        r_p_full <= 1'b0;
      end

      if (w_p_load && r_p_full && !w_w_from_p) begin
        r_overrun <= 1'b1;
      end

      r_rd_valid <= (r_state == FA_SCAN);
      r_rd_idx   <= r_idx;
    end
  end

`ifdef FREQ_SKIP_DC_EN
  // The DC slot still flows through the pipeline timing, just never compared.
  assign w_mag_in_valid = r_rd_valid && (r_rd_idx != 4'd0);
`else
  assign w_mag_in_valid = r_rd_valid;
`endif

  mag_sq u_mag_sq (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_mag_in_valid),
    .i_idx   (r_rd_idx),
    .i_bin   (r_rd_bin),
    .o_valid (w_m_valid),
    .o_idx   (w_m_idx),
    .o_mag   (w_m_mag)
  );

  // Strictly-greater update keeps the lowest index on ties.
  assign w_take    = w_m_valid && ((w_m_idx == c_FIRST_BIN) || (w_m_mag > r_best_mag));
  assign w_new_idx = w_take ? w_m_idx : r_best_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_mag <= '0;
      r_best_idx <= 4'd0;
      r_freq     <= 4'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_take) begin
        r_best_mag <= w_m_mag;
        r_best_idx <= w_m_idx;
      end
      if (w_m_valid && (w_m_idx == c_LAST_BIN)) begin
        r_freq <= w_new_idx;
        r_done <= 1'b1;
      end
    end
  end

  assign freq    = r_freq;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_freq_analyzer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_freq_analyzer : scoreboard bench for freq_analyzer                |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_freq_analyzer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] drv [16];
  logic [31:0] fr  [16];
  logic [3:0]  freq;
  logic        done;
  logic        overrun;

  always #5 clk = ~clk;

  freq_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(drv[0]),   .fft_d1(drv[1]),   .fft_d2(drv[2]),   .fft_d3(drv[3]),
    .fft_d4(drv[4]),   .fft_d5(drv[5]),   .fft_d6(drv[6]),   .fft_d7(drv[7]),
    .fft_d8(drv[8]),   .fft_d9(drv[9]),   .fft_d10(drv[10]), .fft_d11(drv[11]),
    .fft_d12(drv[12]), .fft_d13(drv[13]), .fft_d14(drv[14]), .fft_d15(drv[15]),
    .freq(freq), .done(done), .overrun(overrun)
  );

  typedef struct {
    int f;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_end = 0;
  bit   pend = 1'b0;
  int   pend_f = 0;
  bit   exp_ov = 1'b0;
  bit   prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Peak bin from the rules: first eligible bin seeds, strictly greater wins.
  function automatic int ref_freq(input logic [31:0] f [16]);
    longint best = 0;
    int     bi = 0;
    int     first = 0;
    logic signed [15:0] re, im;
    longint m;
`ifdef FREQ_SKIP_DC_EN
    first = 1;
`endif
    for (int k = first; k < 16; k++) begin
      re = f[k][31:16];
      im = f[k][15:0];
      m  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (k == first || m > best) begin
        best = m;
        bi   = k;
      end
    end
    return bi;
  endfunction

  // Frame-level model: one frame in service for 16 cycles, one waiting slot.
  task automatic model_start(input int f, input int s);
    exp_t e;
    e.f = f;
    e.due = s + 18;
    q.push_back(e);
    busy_end = s + 16;
  endtask

  task automatic model_step(input int t);
    if (pend && busy_end == t) begin
      model_start(pend_f, t);
      pend = 1'b0;
    end
  endtask

  task automatic model_capture(input int t, input int f);
    model_step(t);
    if (!pend && t >= busy_end) begin
      model_start(f, t);
    end else begin
      if (pend) exp_ov = 1'b1;
      pend   = 1'b1;
      pend_f = f;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_step(cyc);
    end
  endtask

  task automatic send_frame();
    for (int k = 0; k < 16; k++) drv[k] = fr[k];
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    model_capture(cyc, ref_freq(fr));
    fft_valid = 1'b0;
  endtask

  task automatic clear_fr();
    for (int k = 0; k < 16; k++) fr[k] = 32'h0;
  endtask

  task automatic drain();
    int budget = 200;
    while ((q.size() != 0 || pend) && budget > 0) begin
      idle(1);
      budget--;
    end
    chk("drain_timeout", int'(q.size() != 0 || pend), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        chk("done_gap", int'(prev_done), 0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("freq", int'(freq), e.f);
          chk("done_cycle", cyc, e.due);
        end
      end
      if (q.size() != 0 && q[0].due < cyc) begin
        chk("missing_done", q[0].due, -1);
        void'(q.pop_front());
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    for (int k = 0; k < 16; k++) drv[k] = 32'h0;
    clear_fr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_freq", int'(freq), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    busy_end = cyc;

    // Tie between bins 1 and 15
    clear_fr();
    fr[1]  = 32'h0100_0000;
    fr[15] = 32'h0100_0000;
    send_frame();
    idle(25);

    // Negative parts
    for (int k = 0; k < 16; k++) fr[k] = 32'h0080_0000;
    fr[7] = 32'hFF00_FF00;
    send_frame();
    idle(25);

    // 64 back-to-back frames, peak rotating
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 16; k++)
        fr[k] = {16'($urandom_range(0, 16'h0200)), 16'($urandom_range(0, 16'h0200))};
      fr[i % 16] = 32'h4000_0000;
      send_frame();
      idle(15);
    end
    drain();
    chk("overrun_rotation", int'(overrun), 0);

    // DC dominance
    clear_fr();
    fr[0] = 32'h7FFF_0000;
    fr[4] = 32'h0100_0000;
    send_frame();
    idle(25);

    // Random frames and gaps
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(1, 24);
      for (int k = 0; k < 16; k++) begin
        if (i % 4 == 0) fr[k] = {16'($urandom_range(0, 2) << 8), 16'h0000};
        else            fr[k] = $urandom;
      end
      send_frame();
      idle(gap - 1);
    end
    drain();
    chk("overrun_random", int'(overrun), int'(exp_ov));

    // Three frames on consecutive cycles
    for (int i = 0; i < 3; i++) begin
      clear_fr();
      fr[3 + i] = 32'h0200_0000;
      send_frame();
    end
    drain();
    chk("overrun_set", int'(overrun), 1);
    idle(5);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset during bin 8 of a scan
    clear_fr();
    fr[9] = 32'h0300_0000;
    send_frame();
    idle(9);
    rst = 1'b1;
    q.delete();
    pend = 1'b0;
    exp_ov = 1'b0;
    #1;
    chk("mid_rst_freq", int'(freq), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_end = cyc;
    idle(25);
    clear_fr();
    fr[12] = 32'h0000_0400;
    send_frame();
    drain();
    idle(3);
    chk("overrun_after_rst", int'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
